rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter. It produces a registered 2-bit grant index plus a valid flag.
- It sits directly upstream of the 2-to-4 decoder. The decoder turns grant_idx into the one-hot grant lines, qualified by grant_valid.
- Once a grant is issued, it is held until the owner releases it, so the downstream one-hot grant stays stable for the whole transaction.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles a grant may be held before forced release; used only when the optional feature is compiled in; legal range 2..255.
- CNT_W, 8, width of the hold-time counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit n high means requester n wants the resource; level-sensitive.
- done  input  1  single-cycle release strobe from the current owner.
- grant_idx  output  2  index of the current owner; feeds the decoder input.
- grant_valid  output  1  high while a grant is held.
- grant_pulse  output  1  one-cycle strobe in the first cycle of each new grant.
- timeout  output  1  one-cycle strobe on forced release; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values (asynchronous, active-high on rst):
  - grant_idx = 2'b00, grant_valid = 0, grant_pulse = 0, timeout = 0.
  - Internal last_idx = 2'b11, so requester 0 has first priority after reset.
  - State = IDLE; hold counter = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- Two states: IDLE and GRANT.
- IDLE:
  - req == 4'b0000: remain in IDLE; grant_valid stays 0.
  - req != 0: at the next edge go to GRANT.
  - Winner is the first set bit scanning last_idx+1, last_idx+2, last_idx+3, last_idx, with indices taken mod 4 (2-bit wrap).
  - On that edge: grant_idx = winner, grant_valid = 1, grant_pulse = 1.
  - Latency: one cycle from sampled req to grant_valid high.
  - done is ignored in IDLE.
- GRANT:
  - grant_idx is held stable. grant_pulse returns to 0 after one cycle.
  - Release condition: done == 1, OR req[grant_idx] == 0 (requester withdrew). Both conditions in the same cycle count as a single release.
  - On release, at the next edge: grant_valid = 0, last_idx = grant_idx, state = IDLE.
  - grant_idx keeps its last value while grant_valid is 0; downstream must gate the decoder output with grant_valid.
  - Requests from other requesters arriving during GRANT are not acted on until IDLE.
- Minimum one IDLE cycle (grant_valid low) between consecutive grants, including back-to-back grants to different requesters.
- A requester holding req high continuously is granted again only after every other active requester has been served (fairness).
- rst asserted mid-GRANT: grant is dropped immediately (asynchronously), and priority restarts from requester 0.
- Sole requester: the scan wraps to last_idx itself, so the same requester is re-granted after the one IDLE gap.

Optional Feature:
- Macro: RR_ARBITER_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with no release in that cycle, the next edge forces release exactly as a normal release would (grant_valid = 0, last_idx updated, IDLE), and timeout pulses high for one cycle.
  - A normal release in the same cycle takes precedence, and timeout stays 0.
- Not defined:
  - No counter is implemented; timeout is tied to 0.
  - A grant may be held indefinitely.

Test Plan:
1. Reset then req = 4'b1111 → grant_idx = 0 with grant_valid = 1 and grant_pulse = 1 one cycle later. Each subsequent done pulse, followed by one IDLE cycle, yields grants in the order 1, 2, 3, 0.
2. req = 4'b0100 only, done pulsed every grant → grant_idx = 2 every time. grant_valid pattern is 1 (hold), 0 (one-cycle gap), 1, ...
3. With grant_idx = 1 held, req drops to 4'b1000 → next cycle grant_valid = 0; the cycle after, grant_idx = 3, grant_valid = 1.
4. req = 4'b0001 held with done = 1 asserted in IDLE → done has no effect. A grant to 0 is issued, and the grant_pulse count equals exactly 1.
5. rst pulsed while grant_idx = 2 is held → grant_valid = 0 immediately. With req = 4'b0101 afterwards, the next grant is idx 0, not 2.
6. RR_ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4, req = 4'b0011, done never asserted:
   - Grant to 0 lasts exactly 4 cycles, then timeout pulses for 1 cycle with grant_valid = 0.
   - After the one-cycle gap, grant goes to 1.
   - Same stimulus without the macro → grant to 0 persists for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a registered
// grant index and valid flag, intended to drive a 2-to-4 decoder.
// A grant is held until the owner pulses done or drops its request.
// The scan starts one past the previous owner, so service rotates fairly.
// Optional forced release after TIMEOUT_CYCLES is compiled in with the
// macro RR_ARBITER_TIMEOUT_EN; otherwise timeout is tied low.
module rr_arbiter_4 #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       grant_pulse,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] last_idx;
  logic [1:0] last_nx;
  logic [1:0] idx_nx;
  logic       valid_nx;
  logic       pulse_nx;
  logic       timeout_nx;
  logic [1:0] winner;
  logic       release_req;
  logic       force_rel;

  // Reject parameter sets the hold counter cannot represent.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
      (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("rr_arbiter_4: illegal TIMEOUT_CYCLES/CNT_W combination");
  end

  // Round-robin scan: last_idx+1 .. last_idx+3, then last_idx itself.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    winner = last_idx;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_nx;

  // Hold counter: zero while idle so it reads 0 in the first grant cycle.
  always_comb begin
    cnt_nx = '0;
    if (state == GRANT) begin
      cnt_nx = hold_cnt + 1'b1;
    end
  end

  // Forced release only when no normal release happens in the same cycle.
  always_comb begin
    force_rel = (state == GRANT) && !release_req &&
                (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Hold counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= cnt_nx;
    end
  end
`else
  // Without the timeout feature a grant may be held indefinitely.
  always_comb begin
    force_rel = 1'b0;
  end
`endif

  // Owner releases by strobing done or by withdrawing its request.
  always_comb begin
    release_req = done || !req[grant_idx];
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_nx   = state;
    idx_nx     = grant_idx;
    last_nx    = last_idx;
    valid_nx   = grant_valid;
    pulse_nx   = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        // done is deliberately not examined here.
        if (req != 4'b0000) begin
          state_nx = GRANT;
          idx_nx   = winner;
          valid_nx = 1'b1;
          pulse_nx = 1'b1;
        end
      end
      GRANT: begin
        if (release_req || force_rel) begin
          state_nx   = IDLE;
          valid_nx   = 1'b0;
          last_nx    = grant_idx;
          timeout_nx = force_rel;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  // State and output registers; every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_idx   <= 2'b00;
      grant_valid <= 1'b0;
      grant_pulse <= 1'b0;
      timeout     <= 1'b0;
      last_idx    <= 2'b11;
    end else begin
      state       <= state_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      grant_pulse <= pulse_nx;
      timeout     <= timeout_nx;
      last_idx    <= last_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed and randomized checks of rr_arbiter_4 against
// a transaction-level reference model. Honours RR_ARBITER_TIMEOUT_EN.
module tb_rr_arbiter_4;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       grant_pulse;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_valid;
  bit m_pulse;
  bit m_to;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_pulse (grant_pulse),
    .timeout     (timeout)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = 0;
    m_last  = 3;
    m_cnt   = 0;
    m_valid = 0;
    m_pulse = 0;
    m_to    = 0;
  endfunction

  // One clock of the arbiter's rules, given the inputs seen at that edge.
  function automatic void model_step(input logic [3:0] r, input logic d);
    bit rel;
    bit forced;
    m_pulse = 0;
    m_to    = 0;
    if (m_valid) begin
      rel    = d || !r[m_owner];
      forced = 0;
`ifdef RR_ARBITER_TIMEOUT_EN
      if (!rel && m_cnt == TO - 1) forced = 1;
`endif
      if (rel || forced) begin
        m_valid = 0;
        m_last  = m_owner;
        m_to    = forced;
      end else begin
        m_cnt++;
      end
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        if (!m_valid && r[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_valid = 1;
          m_pulse = 1;
          m_cnt   = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("grant_idx",   8'(grant_idx),   8'(m_owner));
    check("grant_valid", 8'(grant_valid), 8'(m_valid));
    check("grant_pulse", 8'(grant_pulse), 8'(m_pulse));
    check("timeout",     8'(timeout),     8'(m_to));
  endtask

  // Drive inputs for the next edge, advance the model, sample mid-cycle.
  task automatic cycle(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [3:0] r;
    int pulses;
    int order [4] = '{1, 2, 3, 0};
    req  = 4'b0000;
    done = 1'b0;
    do_reset();

    // 1: all requesting, rotation 0,1,2,3,0 with a gap between grants.
    cycle(4'b1111, 1'b0);
    check("t1_first_idx", 8'(grant_idx), 8'd0);
    check("t1_first_pulse", 8'(grant_pulse), 8'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 1'b1);
      check("t1_gap", 8'(grant_valid), 8'd0);
      cycle(4'b1111, 1'b0);
      check("t1_order", 8'(grant_idx), 8'(order[i]));
    end

    // 2: sole requester 2 is re-granted every time.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    check("t2_idx", 8'(grant_idx), 8'd2);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b1);
      check("t2_gap", 8'(grant_valid), 8'd0);
      cycle(4'b0100, 1'b0);
      check("t2_regrant", 8'(grant_idx), 8'd2);
    end
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // 3: owner 1 withdraws while 3 waits.
    cycle(4'b0010, 1'b0);
    check("t3_idx1", 8'(grant_idx), 8'd1);
    cycle(4'b1010, 1'b0);
    cycle(4'b1000, 1'b0);
    check("t3_drop", 8'(grant_valid), 8'd0);
    cycle(4'b1000, 1'b0);
    check("t3_idx3", 8'(grant_idx), 8'd3);
    check("t3_valid", 8'(grant_valid), 8'd1);

    // 4: done in IDLE is ignored; exactly one grant pulse.
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    pulses = 0;
    cycle(4'b0001, 1'b1);
    pulses += int'(grant_pulse);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 1'b0);
      pulses += int'(grant_pulse);
    end
    check("t4_pulses", 8'(pulses), 8'd1);
    check("t4_held", 8'(grant_valid), 8'd1);

    // 5: asynchronous reset mid-grant, priority restarts at 0.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b0);
    check("t5_idx2", 8'(grant_idx), 8'd2);
    #2 rst = 1'b1;
    #1 check("t5_async_drop", 8'(grant_valid), 8'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    cycle(4'b0101, 1'b0);
    check("t5_restart", 8'(grant_idx), 8'd0);

    // 6: done never asserted with two requesters.
    do_reset();
    cycle(4'b0011, 1'b0);
    check("t6_idx0", 8'(grant_idx), 8'd0);
`ifdef RR_ARBITER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0011, 1'b0);
      check("t6_hold", 8'(grant_valid), 8'd1);
    end
    cycle(4'b0011, 1'b0);
    check("t6_forced", 8'(grant_valid), 8'd0);
    check("t6_timeout", 8'(timeout), 8'd1);
    cycle(4'b0011, 1'b0);
    check("t6_next", 8'(grant_idx), 8'd1);
    check("t6_to_clear", 8'(timeout), 8'd0);
`else
    for (int i = 0; i < 110; i++) begin
      cycle(4'b0011, 1'b0);
    end
    check("t6_persist_valid", 8'(grant_valid), 8'd1);
    check("t6_persist_idx", 8'(grant_idx), 8'd0);
    check("t6_no_timeout", 8'(timeout), 8'd0);
`endif

    // Randomized traffic against the model.
    r = 4'b0000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      cycle(r, ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
